// File: rtl/core_arb_pkg.sv
// Shared types and default constants for the core job arbiter.
// The FSM state encoding and the core's end-of-program opcode live here.
package core_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4
  } arb_state_t;

  localparam logic [3:0] OP_END    = 4'b0000;
  localparam int         PC_W_DEF  = 10;
  localparam int         CNT_W_DEF = 16;

endpackage

// File: rtl/core_job_arbiter_rr_picker.sv
// Combinational round-robin select: first set request searching upward
// from i_last_idx+1, wrapping modulo N.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last_idx,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int off = N; off >= 1; off--) begin
      w_cand = IDX_W'((int'(i_last_idx) + off) % N);
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/core_job_arbiter.sv
// Shares one processor core between NUM_REQ requesters (round-robin launch,
// run-length report). Optional watchdog abort: define CORE_ARB_WATCHDOG_EN.
module core_job_arbiter
  import core_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int PC_W       = PC_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WDOG_LIMIT = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      job_req,
  input  logic [NUM_REQ*PC_W-1:0] job_start_pc,
  output logic [NUM_REQ-1:0]      job_grant,
  output logic [NUM_REQ-1:0]      job_done,
  output logic                    job_err,
  output logic [CNT_W-1:0]        last_run_cycles,
  output logic                    core_req,
  output logic [PC_W-1:0]         core_start_pc,
  input  logic                    core_ack,
  output logic                    core_abort
);

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] WDOG_CNT = CNT_W'(WDOG_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
`ifdef CORE_ARB_WATCHDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  arb_state_t       r_state, w_next;
  logic [IDX_W-1:0] r_grant_idx, r_last_idx, w_pick_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err, w_pick_valid, w_busy, w_wdog_hit;

  rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .i_req      (job_req),
    .i_last_idx (r_last_idx),
    .o_valid    (w_pick_valid),
    .o_idx      (w_pick_idx)
  );

  assign w_busy     = (r_state == WAIT_BUSY) || (r_state == RUN);
  assign w_wdog_hit = WDOG_EN && w_busy && (r_cnt == WDOG_CNT);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; the watchdog outranks the core's idle flag.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (core_ack && w_pick_valid) w_next = LAUNCH; else w_next = IDLE;
      LAUNCH:    w_next = WAIT_BUSY;
      WAIT_BUSY: if (w_wdog_hit) w_next = DONE; else if (!core_ack) w_next = RUN; else w_next = WAIT_BUSY;
      RUN:       if (w_wdog_hit || core_ack) w_next = DONE; else w_next = RUN;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Outputs decoded from state and registers only.
  always_comb begin
    job_grant  = '0;
    job_done   = '0;
    job_err    = 1'b0;
    core_req   = (r_state == LAUNCH);
    core_abort = w_wdog_hit;
    if (r_state != IDLE) job_grant[r_grant_idx] = 1'b1;
    else                 job_grant = '0;
    if (r_state == DONE) begin
      job_done[r_grant_idx] = 1'b1;
      job_err               = r_err;
    end else begin
      job_done = '0;
      job_err  = 1'b0;
    end
  end

  // Grant/PC capture, saturating run counter and completion bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant_idx     <= '0;
      r_last_idx      <= IDX_W'(NUM_REQ - 1);
      r_cnt           <= '0;
      r_err           <= 1'b0;
      core_start_pc   <= '0;
      last_run_cycles <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (core_ack && w_pick_valid) begin
            r_grant_idx   <= w_pick_idx;
            core_start_pc <= job_start_pc[w_pick_idx*PC_W +: PC_W];
          end
        end
        LAUNCH: begin
          r_cnt <= '0;
          r_err <= 1'b0;
        end
        WAIT_BUSY, RUN: begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
          r_err <= w_wdog_hit;
        end
        DONE: begin
          last_run_cycles <= r_cnt;
          r_last_idx      <= r_grant_idx;
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
